// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding and default bus widths
// (the bus widths are also used by the SPI_WB controller).
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } wb_arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester found scanning upward
// from i_last+1 (mod N_MASTERS), returned as one-hot grant, index and valid.
module rr_pick
  import wb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int LW        = idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [LW-1:0]        i_last,
  output logic [N_MASTERS-1:0] o_gnt,
  output logic [LW-1:0]        o_idx,
  output logic                 o_valid
);

  int                   w_j;
  logic [N_MASTERS-1:0] w_rot;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    w_rot   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_j   = (int'(i_last) + k) % N_MASTERS;
      w_rot = i_req >> w_j;
      if (!o_valid && w_rot[0]) begin
        o_valid = 1'b1;
        o_idx   = LW'(w_j);
        o_gnt   = N_MASTERS'(1) << w_j;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: grant is locked for the owner's whole
// cyc tenure, and a watchdog aborts a strobe the slave never answers.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = WB_ADDR_W,
  parameter int DATA_W    = WB_DATA_W,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTERS-1:0]                 m_cyc,
  input  logic [N_MASTERS-1:0]                 m_stb,
  input  logic [N_MASTERS-1:0]                 m_we,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]     m_adr,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]     m_dat_w,
  input  logic [N_MASTERS-1:0][DATA_W/8-1:0]   m_sel,
  output logic [DATA_W-1:0]                    m_dat_r,
  output logic [N_MASTERS-1:0]                 m_ack,
  output logic [N_MASTERS-1:0]                 m_err,
  output logic                                 s_cyc,
  output logic                                 s_stb,
  output logic                                 s_we,
  output logic [ADDR_W-1:0]                    s_adr,
  output logic [DATA_W-1:0]                    s_dat_w,
  output logic [DATA_W/8-1:0]                  s_sel,
  input  logic [DATA_W-1:0]                    s_dat_r,
  input  logic                                 s_ack,
  input  logic                                 s_err,
  output logic [N_MASTERS-1:0]                 grant,
  output logic                                 timeout_evt
);

  localparam int   LW    = idx_w(N_MASTERS);
  localparam int   CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit   WD_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  wb_arb_state_t        r_state,  w_state_nxt;
  logic [LW-1:0]        r_owner,  w_owner_nxt;
  logic [LW-1:0]        r_last,   w_last_nxt;
  logic [N_MASTERS-1:0] r_grant,  w_grant_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic                 r_tevt,   w_tevt_nxt;

  logic [N_MASTERS-1:0] w_pick_gnt;
  logic [LW-1:0]        w_pick_idx;
  logic                 w_pick_vld;

  logic w_owned;
  logic w_own_cyc;
  logic w_stall;

  rr_pick #(
    .N_MASTERS (N_MASTERS),
    .LW        (LW)
  ) u_pick (
    .i_req   (m_cyc),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  // Slave side is a pure mux of the owner; ABORT and IDLE keep it quiet.
  assign w_owned   = (r_state == OWNED);
  assign w_own_cyc = m_cyc[r_owner];

  assign s_cyc   = w_owned & w_own_cyc;
  assign s_stb   = s_cyc & m_stb[r_owner];
  assign s_we    = m_we[r_owner];
  assign s_adr   = m_adr[r_owner];
  assign s_dat_w = m_dat_w[r_owner];
  assign s_sel   = m_sel[r_owner];

  assign m_dat_r     = s_dat_r;
  assign grant       = r_grant;
  assign timeout_evt = r_tevt;

  assign w_stall = s_stb & ~s_ack & ~s_err;

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (w_owned) begin
      m_ack = N_MASTERS'(s_ack) << r_owner;
      m_err = N_MASTERS'(s_err) << r_owner;
    end else if (r_state == ABORT) begin
      m_err = N_MASTERS'(r_tevt) << r_owner;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = '0;
    w_tevt_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = OWNED;
          w_grant_nxt = w_pick_gnt;
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
        end
      end
      OWNED: begin
        // Release wins over a coincident watchdog expiry.
        if (!w_own_cyc) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end else if (WD_EN && w_stall) begin
          if (r_cnt == CNT_MAX) begin
            w_state_nxt = ABORT;
            w_tevt_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ABORT: begin
        if (!w_own_cyc) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= LW'(N_MASTERS - 1);
      r_grant <= '0;
      r_cnt   <= '0;
      r_tevt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tevt  <= w_tevt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter (2 masters, TIMEOUT=16): directed scenarios then
// random traffic, every cycle compared against a tenure-level reference model.
module tb_wb_rr_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic               clk;
  logic               rst;
  logic [N-1:0]       m_cyc, m_stb, m_we;
  logic [N-1:0][AW-1:0] m_adr;
  logic [N-1:0][DW-1:0] m_dat_w;
  logic [N-1:0][SW-1:0] m_sel;
  logic [DW-1:0]      m_dat_r;
  logic [N-1:0]       m_ack, m_err;
  logic               s_cyc, s_stb, s_we;
  logic [AW-1:0]      s_adr;
  logic [DW-1:0]      s_dat_w;
  logic [SW-1:0]      s_sel;
  logic [DW-1:0]      s_dat_r;
  logic               s_ack, s_err;
  logic [N-1:0]       grant;
  logic               timeout_evt;

  wb_rr_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_cyc       (m_cyc),
    .m_stb       (m_stb),
    .m_we        (m_we),
    .m_adr       (m_adr),
    .m_dat_w     (m_dat_w),
    .m_sel       (m_sel),
    .m_dat_r     (m_dat_r),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .s_cyc       (s_cyc),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_adr       (s_adr),
    .s_dat_w     (s_dat_w),
    .s_sel       (s_sel),
    .s_dat_r     (s_dat_r),
    .s_ack       (s_ack),
    .s_err       (s_err),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  // Reference model: who owns the bus (-1 = nobody), whether the tenure was
  // aborted, how many cycles the current strobe has gone unanswered.
  int mdl_owner = -1;
  int mdl_last  = N - 1;
  int mdl_wait  = 0;
  bit mdl_abort = 1'b0;
  bit mdl_tevt  = 1'b0;

  // Slave stimulus: answer on the slv_delay-th consecutive strobe (0 = never).
  int          slv_delay = 1;
  int          slv_cnt   = 0;
  bit          force_ack = 1'b0;
  bit          err_rand  = 1'b0;
  bit          rand_dat  = 1'b0;
  logic [31:0] rdat      = 32'h1;

  int evt_cnt    = 0;
  bit lock_mode  = 1'b0;
  int lock_beat  = 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic slave_drive();
    s_ack = 1'b0;
    s_err = 1'b0;
    s_dat_r = rand_dat ? $urandom : rdat;
    if (force_ack) s_ack = 1'b1;
    else if (s_stb === 1'b1 && slv_delay > 0 && slv_cnt + 1 >= slv_delay) begin
      if (err_rand && $urandom_range(0, 7) == 0) s_err = 1'b1;
      else s_ack = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic         oi;
    bit           act;
    logic [N-1:0] e_grant, e_ack, e_err;
    logic         e_cyc, e_stb;
    oi      = 1'(mdl_owner < 0 ? 0 : mdl_owner);
    act     = (mdl_owner >= 0) && !mdl_abort;
    e_grant = (mdl_owner >= 0) ? (2'b01 << oi) : 2'b00;
    e_cyc   = act && m_cyc[oi];
    e_stb   = e_cyc && m_stb[oi];
    e_ack   = (act && s_ack) ? (2'b01 << oi) : 2'b00;
    e_err   = 2'b00;
    if (mdl_owner >= 0 && (mdl_abort ? mdl_tevt : s_err)) e_err = 2'b01 << oi;
    check_eq("grant", 64'(grant), 64'(e_grant));
    check_eq("s_cyc", 64'(s_cyc), 64'(e_cyc));
    check_eq("s_stb", 64'(s_stb), 64'(e_stb));
    check_eq("m_ack", 64'(m_ack), 64'(e_ack));
    check_eq("m_err", 64'(m_err), 64'(e_err));
    check_eq("timeout_evt", 64'(timeout_evt), 64'(mdl_tevt));
    check_eq("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
    if (e_cyc) begin
      check_eq("s_we", 64'(s_we), 64'(m_we[oi]));
      check_eq("s_adr", 64'(s_adr), 64'(m_adr[oi]));
      check_eq("s_dat_w", 64'(s_dat_w), 64'(m_dat_w[oi]));
      check_eq("s_sel", 64'(s_sel), 64'(m_sel[oi]));
    end
  endtask

  task automatic model_step();
    logic oi;
    bit   t;
    t = 1'b0;
    if (!rst) begin
      mdl_owner = -1;
      mdl_last  = N - 1;
      mdl_wait  = 0;
      mdl_abort = 1'b0;
    end else if (mdl_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (mdl_owner < 0 && m_cyc[1'((mdl_last + k) % N)]) begin
          mdl_owner = (mdl_last + k) % N;
          mdl_last  = mdl_owner;
          mdl_wait  = 0;
        end
      end
    end else begin
      oi = 1'(mdl_owner);
      if (!m_cyc[oi]) begin
        mdl_owner = -1;
        mdl_abort = 1'b0;
        mdl_wait  = 0;
      end else if (!mdl_abort) begin
        if (m_stb[oi] && !s_ack && !s_err) begin
          if (mdl_wait == TMO) begin
            mdl_abort = 1'b1;
            t         = 1'b1;
            mdl_wait  = 0;
          end else mdl_wait++;
        end else mdl_wait = 0;
      end
    end
    mdl_tevt = t;
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the
  // falling edge; the model advances on the rising edge.
  task automatic tick();
    #1;
    slave_drive();
    @(negedge clk);
    compare_outputs();
    if (timeout_evt === 1'b1) evt_cnt++;
    if (lock_mode && m_ack[1] === 1'b1) begin
      check_eq("lock_dat", 64'(m_dat_r), 64'(lock_beat));
      lock_beat++;
    end
    if (s_ack && s_stb === 1'b1) rdat++;
    if (s_stb === 1'b1 && !s_ack && !s_err) slv_cnt++;
    else slv_cnt = 0;
    @(posedge clk);
    model_step();
    cyc_no++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_m(input logic i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[i]   = cyc;
    m_stb[i]   = stb;
    m_we[i]    = we;
    m_adr[i]   = adr;
    m_dat_w[i] = dat;
    m_sel[i]   = 4'hF;
  endtask

  task automatic rand_master(input logic i);
    if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 3) == 0);
    else if ($urandom_range(0, 39) == 0) m_cyc[i] = 1'b0;
    m_stb[i]   = 1'($urandom_range(0, 1));
    m_we[i]    = 1'($urandom_range(0, 1));
    m_adr[i]   = $urandom;
    m_dat_w[i] = $urandom;
    m_sel[i]   = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset held with every master requesting
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    ticks(3);
    check_eq("rst_grant", 64'(grant), 64'h0);

    // Single write from master 0, acked on its third strobe cycle
    rst = 1'b1;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(2);
    slv_delay = 3;
    set_m(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA5);
    tick();
    check_eq("wr_grant", 64'(grant), 64'h1);
    ticks(5);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(3);

    // Fairness from reset: 0, then 1, then 0 again
    rst = 1'b0;
    tick();
    rst = 1'b1;
    slv_delay = 1;
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h11);
    ticks(4);
    check_eq("fair_first", 64'(grant), 64'h1);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(2);
    check_eq("fair_second", 64'(grant), 64'h2);
    ticks(2);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(3);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
    ticks(3);
    check_eq("fair_repeat", 64'(grant), 64'h1);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(2);

    // Lock: master 1 keeps cyc over three reads while master 0 waits
    rdat = 32'h1;
    lock_mode = 1'b1;
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    tick();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    ticks(3);
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    ticks(2);
    check_eq("lock_held", 64'(grant), 64'h2);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(4);
    lock_mode = 1'b0;
    check_eq("lock_beats", 64'(lock_beat), 64'd4);
    check_eq("lock_handoff", 64'(grant), 64'h1);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(3);

    // Watchdog: slave never answers, then a stray ack during ABORT
    slv_delay = 0;
    evt_cnt = 0;
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
    ticks(TMO + 4);
    check_eq("wd_state_held", 64'(grant), 64'h1);
    force_ack = 1'b1;
    ticks(2);
    force_ack = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ticks(3);
    check_eq("wd_pulses", 64'(evt_cnt), 64'd1);

    // Mid-transfer reset during a master 1 read
    slv_delay = 2;
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h70, 32'h0);
    ticks(4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    ticks(2);
    check_eq("post_rst_grant", 64'(grant), 64'h1);
    ticks(2);

    // Random traffic
    err_rand = 1'b1;
    rand_dat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      rand_master(1'b0);
      rand_master(1'b1);
      if (c % 64 == 0) slv_delay = $urandom_range(0, 4);
      force_ack = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
